lcd_cursor_editor: RTL

//  Parametrised text-LCD line editor (HD44780-class, 8-bit bus). Runs the LCD power-up init, then

---
 rtl/lcd_cursor_editor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_cursor_editor.sv
// HD44780-class 8-bit line editor: power-up init, then keypad digits, cursor moves,
// backspace and clear, with the cursor tracked as (row, col) and re-addressed on every move.
module lcd_cursor_editor #(
  parameter int COLS      = 16,
  parameter int ROWS      = 2,
  parameter int WRAP_MODE = 0,
  parameter int INIT_DLY  = 70,
  parameter int CMD_DLY   = 30,
  parameter int ADDR_DLY  = 100,
  parameter int CLR_DLY   = 100,
  parameter int STROBE_AT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] number_btn,
  input  logic [3:0] control_btn,
  input  logic [1:0] SW,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic [7:0] LED_out,
  output logic       cur_row,
  output logic [5:0] cur_col,
  output logic       busy
);
  localparam int MAX_A = (INIT_DLY > ADDR_DLY) ? INIT_DLY : ADDR_DLY;
  localparam int MAX_B = (CLR_DLY > 3*CMD_DLY) ? CLR_DLY : 3*CMD_DLY;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_D + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t INIT_END = cnt_t'(INIT_DLY);
  localparam cnt_t SLOT_END = cnt_t'(CMD_DLY - 1);
  localparam cnt_t BKSP_END = cnt_t'(3*CMD_DLY - 1);
  localparam cnt_t ADDR_END = cnt_t'(ADDR_DLY);
  localparam cnt_t CLR_END  = cnt_t'(CLR_DLY);
  localparam cnt_t STB0     = cnt_t'(STROBE_AT);
  localparam cnt_t STB1     = cnt_t'(CMD_DLY + STROBE_AT);
  localparam cnt_t STB2     = cnt_t'(2*CMD_DLY + STROBE_AT);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam bit ROW_WRAP = (WRAP_MODE == 1) && (ROWS == 2);
  localparam logic [8:0] IDLE_W = 9'h00F;

  // State codes double as the LED pattern shown for that state.
  typedef enum logic [7:0] {
    S_DELAY = 8'h80, S_FUNC  = 8'h40, S_DISP   = 8'h20, S_ENTRY = 8'h10,
    S_SETA  = 8'h08, S_IDLE  = 8'h04, S_WRITE  = 8'h02, S_CURSOR = 8'h01,
    S_BKSP  = 8'h03, S_CLEAR = 8'h0C
  } state_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n;
  logic [8:0] word, word_n;          // {RS, DATA}
  logic       row, row_n, r_row, l_row, seed_row, sw_clr, sw_pend;
  logic [5:0] col, col_n, r_col, l_col;
  logic [3:0] digit, digit_n, ctl_q, ctl_p;
  logic [9:0] num_q, num_p;
  logic [1:0] sw_q;

  function automatic logic [3:0] enc(input logic [9:0] v);
    enc = 4'd0;
    for (int k = 1; k < 10; k++)
      if (v[k]) enc = 4'(10 - k);
  endfunction

  assign seed_row = (ROWS == 2) ? SW[1] : 1'b0;

  always_comb begin
    r_col = (col == LAST_COL) ? 6'd0 : col + 6'd1;
    l_col = (col == 6'd0) ? LAST_COL : col - 6'd1;
    r_row = (ROW_WRAP && col == LAST_COL) ? ~row : row;
    l_row = (ROW_WRAP && col == 6'd0) ? ~row : row;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + cnt_t'(1);
    word_n  = IDLE_W;
    row_n   = row;
    col_n   = col;
    digit_n = digit;
    sw_clr  = 1'b0;
    case (state)
      S_DELAY: begin
        word_n = word;
        if (cnt == INIT_END) begin state_n = S_FUNC; cnt_n = '0; end
      end
      S_FUNC: begin
        if (cnt == STB0) word_n = 9'h038;
        if (cnt == SLOT_END) begin state_n = S_DISP; cnt_n = '0; end
      end
      S_DISP: begin
        if (cnt == STB0) word_n = 9'h00F;
        if (cnt == SLOT_END) begin state_n = S_ENTRY; cnt_n = '0; end
      end
      S_ENTRY: begin
        if (cnt == STB0) word_n = 9'h006;
        if (cnt == SLOT_END) begin state_n = S_SETA; cnt_n = '0; sw_clr = 1'b1; end
      end
      S_SETA: begin
        if (cnt == STB0) begin
          word_n = {2'b01, seed_row, 6'd0};
          row_n  = seed_row;
          col_n  = 6'd0;
        end
        if (cnt == ADDR_END) begin state_n = S_IDLE; cnt_n = '0; end
      end
      S_IDLE: begin
        cnt_n = '0;
        if (|num_p) begin
          state_n = S_WRITE;
          digit_n = enc(num_p);
        end else if (ctl_p[3]) state_n = S_CLEAR;
        else if (ctl_p[2]) begin state_n = S_BKSP;   row_n = l_row; col_n = l_col; end
        else if (ctl_p[1]) begin state_n = S_CURSOR; row_n = l_row; col_n = l_col; end
        else if (ctl_p[0]) begin state_n = S_CURSOR; row_n = r_row; col_n = r_col; end
        else if (sw_pend)  begin state_n = S_SETA;   sw_clr = 1'b1; end
      end
      S_WRITE: begin
        if (cnt == STB0) begin
          word_n = {1'b1, 8'h30 + {4'd0, digit}};
          row_n  = r_row;
          col_n  = r_col;
        end
        // Re-address after the write so the cursor position never depends on LCD auto-increment.
        if (cnt == SLOT_END) begin
          word_n  = {2'b01, row, col};
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_CURSOR: begin
        if (cnt == STB0) word_n = {2'b01, row, col};
        if (cnt == SLOT_END) begin state_n = S_IDLE; cnt_n = '0; end
      end
      S_BKSP: begin
        if (cnt == STB0 || cnt == STB2) word_n = {2'b01, row, col};
        if (cnt == STB1) word_n = 9'h120;
        if (cnt == BKSP_END) begin state_n = S_IDLE; cnt_n = '0; end
      end
      S_CLEAR: begin
        if (cnt == STB0) word_n = 9'h001;
        if (cnt == CLR_END) begin state_n = S_SETA; cnt_n = '0; sw_clr = 1'b1; end
      end
      default: begin
        state_n = S_DELAY;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_DELAY;
      cnt     <= '0;
      word    <= 9'h101;
      LED_out <= 8'h00;
      row     <= 1'b0;
      col     <= 6'd0;
      digit   <= 4'd0;
      num_q   <= '0;
      num_p   <= '0;
      ctl_q   <= '0;
      ctl_p   <= '0;
      sw_q    <= '0;
      sw_pend <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      word    <= word_n;
      LED_out <= 8'(state);
      row     <= row_n;
      col     <= col_n;
      digit   <= digit_n;
      num_q   <= number_btn;
      num_p   <= number_btn & ~num_q;
      ctl_q   <= control_btn;
      ctl_p   <= control_btn & ~ctl_q;
      sw_q    <= SW;
      // A change in the same cycle as the clear still counts, so a late flip is never lost.
      sw_pend <= (sw_pend & ~sw_clr) | (SW != sw_q);
    end
  end

  assign LCD_E    = clk;
  assign LCD_RS   = word[8];
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = word[7:0];
  assign cur_row  = row;
  assign cur_col  = col;
  assign busy     = (state != S_IDLE);
endmodule
